// File: rtl/pc_unit_pkg.sv
// Shared types for the program-counter unit: FSM states and redirect sources.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_TRAP   = 2'd1,
        SRC_BRANCH = 2'd2
    } redirect_src_e;

    // Source that the pending slot holds after a capture cycle.
    // A trap always wins; a branch never displaces a pending trap.
    function automatic redirect_src_e merge_src(redirect_src_e pend, logic trap_v, logic br_v);
        redirect_src_e res;
        res = pend;
        if (trap_v) begin
            res = SRC_TRAP;
        end else if (br_v && pend != SRC_TRAP) begin
            res = SRC_BRANCH;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect slot: holds a trap/branch target that arrived
// while the PC could not update, until the next update consumes it.
module pc_redirect_buf
    import pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                capture_i,
    input  logic                clear_i,
    input  logic                trap_valid_i,
    input  logic [XLEN-1:0]     trap_target_i,
    input  logic                br_valid_i,
    input  logic [XLEN-1:0]     br_target_i,
    output redirect_src_e       src_o,
    output logic [XLEN-1:0]     target_o
);

    redirect_src_e   src_q, src_d;
    logic [XLEN-1:0] target_q, target_d;

    always_comb begin
        src_d    = src_q;
        target_d = target_q;
        if (clear_i) begin
            src_d = SRC_NONE;
        end else if (capture_i) begin
            src_d = merge_src(src_q, trap_valid_i, br_valid_i);
            if (trap_valid_i) begin
                target_d = trap_target_i;
            end else if (br_valid_i && src_q != SRC_TRAP) begin
                target_d = br_target_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q    <= SRC_NONE;
            target_q <= '0;
        end else begin
            src_q    <= src_d;
            target_q <= target_d;
        end
    end

    assign src_o    = src_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with BOOT/RUN/HALT control, fetch handshake,
// prioritised trap/branch redirects and a one-entry pending redirect.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            pc_clk,
    input  logic            pc_rst_n,
    input  logic            pc_stall,
    input  logic            pc_halt,
    input  logic            pc_resume,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] PC_CNT,
    output logic [XLEN-1:0] pc_plus,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] INC_X    = XLEN'(INC);
    localparam logic [XLEN-1:0] LOW_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;

    logic            upd;
    logic            capture;
    logic            redir;
    logic [XLEN-1:0] redir_target;
    redirect_src_e   pend_src;
    logic [XLEN-1:0] pend_target;

    assign if_valid = (state_q == ST_RUN);
    assign upd      = (state_q == ST_RUN) & ~pc_stall & (if_ready | ~if_valid);
    assign capture  = ~upd & ((state_q == ST_RUN) | (state_q == ST_HALT));
    assign pc_plus  = pc_q + INC_X;

    pc_redirect_buf #(
        .XLEN(XLEN)
    ) u_redirect_buf (
        .clk_i         (pc_clk),
        .rst_ni        (pc_rst_n),
        .capture_i     (capture),
        .clear_i       (upd),
        .trap_valid_i  (trap_valid),
        .trap_target_i (trap_target),
        .br_valid_i    (br_valid),
        .br_target_i   (br_target),
        .src_o         (pend_src),
        .target_o      (pend_target)
    );

    // Live redirects take precedence over whatever is parked in the slot.
    always_comb begin
        redir        = 1'b0;
        redir_target = '0;
        if (trap_valid) begin
            redir        = 1'b1;
            redir_target = trap_target;
        end else if (br_valid) begin
            redir        = 1'b1;
            redir_target = br_target;
        end else if (pend_src != SRC_NONE) begin
            redir        = 1'b1;
            redir_target = pend_target;
        end
    end

    always_comb begin
        pc_d  = pc_q;
        mis_d = 1'b0;
        if (upd) begin
            if (redir) begin
                pc_d  = redir_target & ~LOW_MASK;
                mis_d = |(redir_target & LOW_MASK);
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (upd && pc_halt) state_d = ST_HALT;
            ST_HALT: if (pc_resume) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge pc_clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    assign PC_CNT       = pc_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Vector-table and scoreboard bench for pc_unit with RESET_VECTOR=0x100.
module tb_pc_unit;

    logic        pc_clk = 1'b0;
    logic        pc_rst_n;
    logic        pc_stall, pc_halt, pc_resume;
    logic        trap_valid, br_valid, if_ready;
    logic [31:0] trap_target, br_target;
    logic        if_valid, misalign_err;
    logic [31:0] PC_CNT, pc_plus;

    int total = 0;
    int bad   = 0;

    always #5 pc_clk = ~pc_clk;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .INC          (4),
        .ALIGN_BITS   (2)
    ) dut (
        .pc_clk       (pc_clk),
        .pc_rst_n     (pc_rst_n),
        .pc_stall     (pc_stall),
        .pc_halt      (pc_halt),
        .pc_resume    (pc_resume),
        .trap_valid   (trap_valid),
        .trap_target  (trap_target),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .if_ready     (if_ready),
        .if_valid     (if_valid),
        .PC_CNT       (PC_CNT),
        .pc_plus      (pc_plus),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic        stall;
        logic        halt;
        logic        resume;
        logic        trap_v;
        logic [31:0] trap_t;
        logic        br_v;
        logic [31:0] br_t;
        logic        rdy;
        logic [31:0] e_pc;
        logic        e_val;
        logic        e_mis;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[32];

    function automatic vec_t mk(logic stall, logic halt, logic resume,
                                logic trap_v, logic [31:0] trap_t,
                                logic br_v, logic [31:0] br_t, logic rdy,
                                logic [31:0] e_pc, logic e_val, logic e_mis);
        vec_t v;
        v.stall = stall; v.halt = halt; v.resume = resume;
        v.trap_v = trap_v; v.trap_t = trap_t;
        v.br_v = br_v; v.br_t = br_t; v.rdy = rdy;
        v.e_pc = e_pc; v.e_val = e_val; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(string tag, vec_t v);
        vec_t e;
        pc_stall    = v.stall;
        pc_halt     = v.halt;
        pc_resume   = v.resume;
        trap_valid  = v.trap_v;
        trap_target = v.trap_t;
        br_valid    = v.br_v;
        br_target   = v.br_t;
        if_ready    = v.rdy;
        exp_q.push_back(v);
        @(posedge pc_clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " pc"}, PC_CNT, e.e_pc);
        check({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, e.e_val});
        check({tag, " misalign"}, {31'd0, misalign_err}, {31'd0, e.e_mis});
        check({tag, " pc_plus"}, pc_plus, e.e_pc + 32'd4);
        $display("step %s: pc=%h if_valid=%0d mis=%0d", tag, PC_CNT, if_valid, misalign_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        stall halt res trap tgt         br  tgt           rdy exp_pc        val mis
        tbl[0]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h100,       1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h104,       1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h108,       1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 32'h80,       1, 32'h200,       1, 32'h80,        1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,        1, 32'h203,       1, 32'h200,       1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h204,       1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC,  1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h4,         1, 0);
        tbl[9]  = mk(1, 0, 0, 0, 32'h0,        1, 32'h400,       1, 32'h4,         1, 0);
        tbl[10] = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h4,         1, 0);
        tbl[11] = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h4,         1, 0);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h400,       1, 0);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h404,       1, 0);
        tbl[14] = mk(1, 0, 0, 1, 32'h800,      0, 32'h0,         1, 32'h404,       1, 0);
        tbl[15] = mk(1, 0, 0, 0, 32'h0,        1, 32'h900,       1, 32'h404,       1, 0);
        tbl[16] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h800,       1, 0);
        tbl[17] = mk(1, 0, 0, 0, 32'h0,        1, 32'hA00,       1, 32'h800,       1, 0);
        tbl[18] = mk(1, 0, 0, 1, 32'hB00,      0, 32'h0,         1, 32'h800,       1, 0);
        tbl[19] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'hB00,       1, 0);
        tbl[20] = mk(1, 0, 0, 1, 32'hC00,      0, 32'h0,         1, 32'hB00,       1, 0);
        tbl[21] = mk(1, 0, 0, 1, 32'hD00,      0, 32'h0,         1, 32'hB00,       1, 0);
        tbl[22] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'hD00,       1, 0);
        tbl[23] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,         1, 32'hD04,       0, 0);
        tbl[24] = mk(0, 0, 0, 0, 32'h0,        1, 32'hE00,       1, 32'hD04,       0, 0);
        tbl[25] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'hD04,       0, 0);
        tbl[26] = mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'hD04,       1, 0);
        tbl[27] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'hE00,       1, 0);
        tbl[28] = mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'hE04,       1, 0);
        tbl[29] = mk(1, 0, 0, 0, 32'h0,        1, 32'h1001,      1, 32'hE04,       1, 0);
        tbl[30] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h1000,      1, 1);
        tbl[31] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h1004,      1, 0);

        pc_rst_n = 1'b0;
        pc_stall = 0; pc_halt = 0; pc_resume = 0;
        trap_valid = 0; trap_target = '0; br_valid = 0; br_target = '0;
        if_ready = 1;
        #12;
        check("reset pc", PC_CNT, 32'h100);
        check("reset if_valid", {31'd0, if_valid}, 32'd0);
        check("reset misalign", {31'd0, misalign_err}, 32'd0);
        pc_rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            step($sformatf("v%0d", i), tbl[i]);
        end

        // Fetch stall with a trap arriving mid-wait, then a branch parked before reset.
        step("rdy_wait0", mk(0, 0, 0, 0, 32'h0,  0, 32'h0,    0, 32'h1004, 1, 0));
        step("rdy_wait1", mk(0, 0, 0, 1, 32'h40, 0, 32'h0,    0, 32'h1004, 1, 0));
        step("rdy_go",    mk(0, 0, 0, 0, 32'h0,  0, 32'h0,    1, 32'h40,   1, 0));
        step("park_br",   mk(0, 0, 0, 0, 32'h0,  1, 32'h3000, 0, 32'h40,   1, 0));

        br_valid = 0;
        #3;
        pc_rst_n = 1'b0;
        #1;
        check("async rst pc", PC_CNT, 32'h100);
        check("async rst if_valid", {31'd0, if_valid}, 32'd0);
        check("async rst misalign", {31'd0, misalign_err}, 32'd0);
        $display("step async_rst: pc=%h if_valid=%0d", PC_CNT, if_valid);
        #2;
        pc_rst_n = 1'b1;

        step("post_boot", mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h100, 1, 0));
        step("post_run1", mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h104, 1, 0));
        step("post_run2", mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h108, 1, 0));

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
